// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: two-requester scheduler that drives an SPI block's APB4 slave
// port. Each grant programs the SPI, starts one read command, streams the
// received words to the owning requester and reports completion or timeout.
module spi_xfer_sched #(
    parameter logic [3:0] NSS_SEL  = 4'b0001,
    parameter int         POLL_MAX = 1024,
    parameter int         LEN_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0][13:0]      req_frame_i,
    input  logic [1:0][31:0]      req_cmd_i,
    input  logic [1:0][31:0]      req_addr_i,
    input  logic [1:0][LEN_W-1:0] req_len_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_id_o,
    output logic                  done_o,
    output logic                  done_id_o,
    output logic                  done_err_o,
    output logic [5:0]            paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    input  logic [31:0]           prdata_i,
    input  logic                  pready_i
);

    localparam int PCW = $clog2(POLL_MAX) + 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

    localparam logic [5:0] A_CTRL  = 6'h00;
    localparam logic [5:0] A_FRAME = 6'h08;
    localparam logic [5:0] A_CMD   = 6'h0C;
    localparam logic [5:0] A_ADDR  = 6'h10;
    localparam logic [5:0] A_TRL   = 6'h1C;
    localparam logic [5:0] A_RXR   = 6'h24;
    localparam logic [5:0] A_STAT  = 6'h28;

    // CTRL start value: nss in [8:5], rwm[4], st[3], en[0].
    localparam logic [31:0] CTRL_GO = 32'({NSS_SEL, 1'b1, 1'b1, 2'b00, 1'b1});

    typedef enum logic [3:0] {
        IDLE, WAIT_IDLE, WR_FRAME, WR_CMD, WR_ADDR, WR_TRL, WR_CTRL,
        POLL_RX, RD_RXR, OUT, WAIT_DONE, ABORT, DONE
    } state_t;

    // Every APB transfer walks idle -> setup -> access, so psel always drops
    // for at least one cycle between two transfers.
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [PCW-1:0]    poll_q, poll_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              err_q, err_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic [13:0]       frame_q;
    logic [31:0]       cmd_q;
    logic [31:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [31:0]       rx_q;

    logic              grant;
    logic              rx_load;
    logic              apb_en;
    logic              apb_wr;
    logic [5:0]        apb_addr;
    logic [31:0]       apb_data;
    logic              xfer_done;
    logic              stat_busy;
    logic              stat_empty;

    assign xfer_done  = penable_o && pready_i;
    assign stat_busy  = prdata_i[2];
    assign stat_empty = prdata_i[4];

    assign psel_o      = apb_en && (phase_q != PH_IDLE);
    assign penable_o   = apb_en && (phase_q == PH_ACCESS);
    assign pwrite_o    = psel_o && apb_wr;
    assign paddr_o     = psel_o ? apb_addr : 6'h00;
    assign pwdata_o    = (psel_o && apb_wr) ? apb_data : 32'h0;

    assign rsp_valid_o = (state_q == OUT);
    assign rsp_data_o  = rx_q;
    assign rsp_id_o    = gnt_q;
    assign done_o      = (state_q == DONE);
    assign done_id_o   = done_o && gnt_q;
    assign done_err_o  = done_o && err_q;

    // Next-state, arbitration, APB decode and poll/word bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        poll_d      = poll_q;
        words_d     = words_q;
        err_d       = err_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        grant       = 1'b0;
        rx_load     = 1'b0;
        req_ready_o = 2'b00;
        apb_en      = 1'b0;
        apb_wr      = 1'b0;
        apb_addr    = A_STAT;
        apb_data    = 32'h0;

        unique case (state_q)
            IDLE: begin
                if ((|req_valid_i) && !rst_i) begin
                    grant       = 1'b1;
                    gnt_d       = (&req_valid_i) ? rr_q : req_valid_i[1];
                    rr_d        = ~gnt_d;
                    req_ready_o = gnt_d ? 2'b10 : 2'b01;
                    words_d     = req_len_i[gnt_d];
                    err_d       = 1'b0;
                    state_d     = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                apb_en = 1'b1;
                if (xfer_done) begin
                    if (!stat_busy)            state_d = WR_FRAME;
                    else if (poll_q == POLL_LAST) state_d = ABORT;
                    else                        poll_d  = poll_q + 1'b1;
                end
            end
            WR_FRAME: begin
                apb_en   = 1'b1;
                apb_wr   = 1'b1;
                apb_addr = A_FRAME;
                apb_data = 32'(frame_q);
                if (xfer_done) state_d = WR_CMD;
            end
            WR_CMD: begin
                apb_en   = 1'b1;
                apb_wr   = 1'b1;
                apb_addr = A_CMD;
                apb_data = cmd_q;
                if (xfer_done) state_d = WR_ADDR;
            end
            WR_ADDR: begin
                apb_en   = 1'b1;
                apb_wr   = 1'b1;
                apb_addr = A_ADDR;
                apb_data = addr_q;
                if (xfer_done) state_d = WR_TRL;
            end
            WR_TRL: begin
                apb_en   = 1'b1;
                apb_wr   = 1'b1;
                apb_addr = A_TRL;
                apb_data = 32'(len_q);
                if (xfer_done) state_d = WR_CTRL;
            end
            WR_CTRL: begin
                apb_en   = 1'b1;
                apb_wr   = 1'b1;
                apb_addr = A_CTRL;
                apb_data = CTRL_GO;
                if (xfer_done) state_d = (len_q != '0) ? POLL_RX : WAIT_DONE;
            end
            POLL_RX: begin
                apb_en = 1'b1;
                if (xfer_done) begin
                    if (!stat_empty)            state_d = RD_RXR;
                    else if (poll_q == POLL_LAST) state_d = ABORT;
                    else                        poll_d  = poll_q + 1'b1;
                end
            end
            RD_RXR: begin
                // Each RXR read pops the SPI RX FIFO, so it is issued exactly once.
                apb_en   = 1'b1;
                apb_addr = A_RXR;
                if (xfer_done) begin
                    rx_load = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (rsp_ready_i) begin
                    if (words_q != '0) words_d = words_q - 1'b1;
                    state_d = (words_q <= 1) ? WAIT_DONE : POLL_RX;
                end
            end
            WAIT_DONE: begin
                apb_en = 1'b1;
                if (xfer_done) begin
                    if (!stat_busy)            state_d = DONE;
                    else if (poll_q == POLL_LAST) state_d = ABORT;
                    else                        poll_d  = poll_q + 1'b1;
                end
            end
            ABORT: begin
                // Clearing en flushes the SPI FIFOs; the command ends in error.
                apb_en   = 1'b1;
                apb_wr   = 1'b1;
                apb_addr = A_CTRL;
                err_d    = 1'b1;
                if (xfer_done) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (apb_en) begin
            unique case (phase_q)
                PH_IDLE:   phase_d = PH_SETUP;
                PH_SETUP:  phase_d = PH_ACCESS;
                PH_ACCESS: if (pready_i) phase_d = PH_IDLE;
                default:   phase_d = PH_IDLE;
            endcase
        end

        if (state_d != state_q) poll_d = '0;
    end

    // State register plus request-field and RX-word capture.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of evaluation order.
        if (rst_i) begin
            state_q <= IDLE;
            phase_q <= PH_IDLE;
            poll_q  <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            frame_q <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            poll_q  <= poll_d;
            words_q <= words_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            if (grant) begin
                frame_q <= req_frame_i[gnt_d];
                cmd_q   <= req_cmd_i[gnt_d];
                addr_q  <= req_addr_i[gnt_d];
                len_q   <= req_len_i[gnt_d];
            end
            if (rx_load) rx_q <= prdata_i;
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed testbench for spi_xfer_sched with a behavioural APB SPI slave.
module tb_spi_xfer_sched;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][13:0] req_frame_i;
    logic [1:0][31:0] req_cmd_i;
    logic [1:0][31:0] req_addr_i;
    logic [1:0][15:0] req_len_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_data_o;
    logic             rsp_id_o;
    logic             done_o;
    logic             done_id_o;
    logic             done_err_o;
    logic [5:0]       paddr_o;
    logic             psel_o;
    logic             penable_o;
    logic             pwrite_o;
    logic [31:0]      pwdata_o;
    logic [31:0]      prdata_i;
    logic             pready_i;

    spi_xfer_sched #(.NSS_SEL(4'b0001), .POLL_MAX(8), .LEN_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_frame_i(req_frame_i), .req_cmd_i(req_cmd_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
        .done_o(done_o), .done_id_o(done_id_o), .done_err_o(done_err_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i)
    );

    always #5 clk = ~clk;

    // Slave model state.
    int          wait_cnt = 0;
    int          stall_len;
    int          rx_rd = 0;
    int          rx_wr = 0;
    int          stat_reads = 0;
    int          busy_until = 0;
    bit          busy_stuck = 0;
    bit          stall_ctrl = 0;
    bit          stall_rxr = 0;
    logic [31:0] rx_mem [16];

    // Monitor logs.
    logic [5:0]  log_addr [256];
    logic        log_wr   [256];
    logic [31:0] log_data [256];
    int          log_n = 0;
    logic [31:0] rsp_data [64];
    logic        rsp_id   [64];
    int          rsp_n = 0;
    logic        done_id  [64];
    logic        done_err [64];
    int          done_n = 0;
    logic        gnt_log  [64];
    int          gnt_n = 0;
    logic [1:0]  rdy_seen = 2'b00;

    int n_checks = 0;
    int n_err = 0;

    // Slave read data and ready: STAT reflects busy and RX FIFO emptiness.
    always_comb begin
        stall_len = 0;
        if (stall_ctrl && paddr_o == 6'h00 && pwrite_o && pwdata_o != 32'h0) stall_len = 5;
        if (stall_rxr && paddr_o == 6'h24) stall_len = 1000;
        pready_i = (wait_cnt >= stall_len);
        prdata_i = 32'h0;
        if (paddr_o == 6'h28)
            prdata_i = {27'd0, (rx_rd == rx_wr), 1'b0,
                        (busy_stuck || stat_reads < busy_until), 2'b00};
        else if (paddr_o == 6'h24)
            prdata_i = rx_mem[rx_rd[3:0]];
    end

    // Slave side effects at the completing edge.
    always @(posedge clk) begin
        if (psel_o && penable_o && pready_i) begin
            wait_cnt <= 0;
            if (!pwrite_o && paddr_o == 6'h24) rx_rd <= rx_rd + 1;
            if (!pwrite_o && paddr_o == 6'h28) stat_reads <= stat_reads + 1;
        end else if (psel_o && penable_o) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Monitor sampled mid-cycle: events here take effect at the next posedge.
    always @(negedge clk) begin
        if (psel_o && penable_o && pready_i && log_n < 256) begin
            log_addr[log_n] = paddr_o;
            log_wr[log_n]   = pwrite_o;
            log_data[log_n] = pwrite_o ? pwdata_o : prdata_i;
            log_n++;
        end
        if (rsp_valid_o && rsp_ready_i && rsp_n < 64) begin
            rsp_data[rsp_n] = rsp_data_o;
            rsp_id[rsp_n]   = rsp_id_o;
            rsp_n++;
        end
        if (done_o && done_n < 64) begin
            done_id[done_n]  = done_id_o;
            done_err[done_n] = done_err_o;
            done_n++;
        end
        if (req_ready_o != 2'b00 && gnt_n < 64) begin
            gnt_log[gnt_n] = req_ready_o[1];
            gnt_n++;
        end
        rdy_seen = req_ready_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic load_rx(input logic [31:0] w);
        rx_mem[rx_wr[3:0]] = w;
        rx_wr++;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    // Raise one request and hold it until accepted; reports cycles waited.
    task automatic issue(input int r, input logic [13:0] fr, input logic [31:0] cm,
                         input logic [31:0] ad, input logic [15:0] ln,
                         input string tag, output int waited);
        bit got = 0;
        logic [1:0] rdy = 2'b00;
        waited = 0;
        req_frame_i[r] = fr;
        req_cmd_i[r]   = cm;
        req_addr_i[r]  = ad;
        req_len_i[r]   = ln;
        req_valid_i[r] = 1'b1;
        #1;
        for (int k = 0; k < 300 && !got; k++) begin
            if (req_ready_o[r]) begin
                got = 1;
                rdy = req_ready_o;
                waited = k;
            end
            @(posedge clk);
            #1;
        end
        req_valid_i[r] = 1'b0;
        check(tag, {30'd0, rdy}, (r == 1) ? 32'd2 : 32'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int k = 0; k < 400 && done_n < target; k++) begin
            @(posedge clk);
            #1;
        end
        check(tag, done_n, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    logic [5:0]  e_addr [11] = '{6'h28, 6'h08, 6'h0C, 6'h10, 6'h1C, 6'h00,
                                 6'h28, 6'h24, 6'h28, 6'h24, 6'h28};
    logic [31:0] e_data [11] = '{32'h0, 32'h123, 32'h3, 32'h1000, 32'h2, 32'h39,
                                 32'h0, 32'hA5A5_0001, 32'h0, 32'hA5A5_0002, 32'h10};
    logic        e_wr   [11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    initial begin
        int base, r0, d0, g0, w, acc, bad_d, bad_p, bad_v, cnt_stat, cnt_rxr, cnt_ctrl;
        logic [1:0] pair_mask;
        rst_i       = 1'b1;
        req_valid_i = 2'b00;
        req_frame_i = '0;
        req_cmd_i   = '0;
        req_addr_i  = '0;
        req_len_i   = '0;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state: every output low.
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_paddr_pwdata", {paddr_o, pwdata_o[25:0]}, 0);
        check("rst_rsp_done", {rsp_valid_o, done_o, done_err_o, req_ready_o}, 0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Single read from requester 0.
        load_rx(32'hA5A5_0001);
        load_rx(32'hA5A5_0002);
        base = log_n; r0 = rsp_n; d0 = done_n;
        issue(0, 14'h0123, 32'h03, 32'h1000, 16'd2, "t1_ready", w);
        wait_done(d0 + 1, "t1_done");
        check("t1_log_n", log_n - base, 11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t1_addr%0d", i), log_addr[base+i], e_addr[i]);
            check($sformatf("t1_data%0d", i), {log_wr[base+i], log_data[base+i][30:0]},
                  {e_wr[i], e_data[i][30:0]});
        end
        check("t1_rsp_n", rsp_n - r0, 2);
        check("t1_rsp0", rsp_data[r0], 32'hA5A5_0001);
        check("t1_rsp1", rsp_data[r0+1], 32'hA5A5_0002);
        check("t1_rsp_id", {rsp_id[r0], rsp_id[r0+1]}, 0);
        check("t1_done_id_err", {done_id[d0], done_err[d0]}, 0);

        // Round robin: both valid together, two rounds, from a fresh pointer.
        pulse_reset();
        @(posedge clk);
        #1;
        g0 = gnt_n; d0 = done_n;
        req_len_i = '0;
        for (int round = 0; round < 2; round++) begin
            pair_mask = 2'b11;
            req_valid_i = pair_mask;
            for (int k = 0; k < 400 && (req_valid_i != 2'b00 || done_n < d0 + 2*round + 2); k++) begin
                @(posedge clk);
                #1;
                req_valid_i = req_valid_i & ~rdy_seen;
            end
        end
        check("t2_gnt_n", gnt_n - g0, 4);
        check("t2_gnt_seq", {gnt_log[g0], gnt_log[g0+1], gnt_log[g0+2], gnt_log[g0+3]}, 4'b0101);
        check("t2_done_n", done_n - d0, 4);
        check("t2_done_ids", {done_id[d0], done_id[d0+1], done_id[d0+2], done_id[d0+3]}, 4'b0101);
        check("t2_done_errs", {done_err[d0], done_err[d0+1], done_err[d0+2], done_err[d0+3]}, 0);

        // Response backpressure for 20 cycles.
        load_rx(32'h1111_1111);
        load_rx(32'h2222_2222);
        rsp_ready_i = 1'b0;
        r0 = rsp_n; d0 = done_n;
        issue(1, 14'h0002, 32'h0B, 32'h2000, 16'd2, "t3_ready", w);
        for (int k = 0; k < 200 && !rsp_valid_o; k++) begin
            @(posedge clk);
            #1;
        end
        check("t3_rsp_valid", rsp_valid_o, 1);
        base = log_n;
        bad_d = 0; bad_p = 0; bad_v = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_data_o !== 32'h1111_1111) bad_d++;
            if (psel_o !== 1'b0) bad_p++;
            if (rsp_valid_o !== 1'b1) bad_v++;
        end
        @(posedge clk);
        #1;
        check("t3_hold_data", bad_d, 0);
        check("t3_hold_nobus", bad_p, 0);
        check("t3_hold_valid", bad_v, 0);
        check("t3_hold_log", log_n - base, 0);
        check("t3_hold_words", dut.words_q, 2);
        rsp_ready_i = 1'b1;
        wait_done(d0 + 1, "t3_done");
        check("t3_after_poll", {log_wr[base], log_addr[base]}, 7'h28);
        check("t3_after_rxr", {log_wr[base+1], log_addr[base+1]}, 7'h24);
        check("t3_rsp_data", {rsp_data[r0], rsp_data[r0+1]}, {32'h1111_1111, 32'h2222_2222});
        check("t3_rsp_id", {rsp_id[r0], rsp_id[r0+1], done_id[d0]}, 3'b111);

        // CTRL write stalled 5 cycles, len=0, busy for the first 3 STAT reads.
        stall_ctrl = 1;
        busy_until = stat_reads + 3;
        base = log_n; r0 = rsp_n; d0 = done_n;
        acc = 0; bad_d = 0;
        req_frame_i[0] = 14'h0001; req_cmd_i[0] = 32'h9F; req_addr_i[0] = 32'h0; req_len_i[0] = 16'd0;
        req_valid_i[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i[0] = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (psel_o && penable_o && paddr_o == 6'h00 && pwrite_o) begin
                acc++;
                if (pwdata_o !== 32'h39) bad_d++;
            end
        end
        @(posedge clk);
        #1;
        stall_ctrl = 0;
        cnt_stat = 0; cnt_rxr = 0; cnt_ctrl = 0;
        for (int i = base; i < log_n; i++) begin
            if (log_addr[i] == 6'h28 && !log_wr[i]) cnt_stat++;
            if (log_addr[i] == 6'h24) cnt_rxr++;
            if (log_addr[i] == 6'h00 && log_wr[i]) cnt_ctrl++;
        end
        check("t4_access_cycles", acc, 6);
        check("t4_pwdata_held", bad_d, 0);
        check("t4_ctrl_writes", cnt_ctrl, 1);
        check("t4_log_n", log_n - base, 10);
        check("t4_stat_reads", cnt_stat, 5);
        check("t4_no_rxr", cnt_rxr, 0);
        check("t4_done", done_n - d0, 1);
        check("t4_done_id_err", {done_id[d0], done_err[d0]}, 0);
        check("t4_no_rsp", rsp_n - r0, 0);

        // Timeout: busy stuck while waiting for idle.
        busy_stuck = 1;
        base = log_n; r0 = rsp_n; d0 = done_n;
        issue(0, 14'h0003, 32'h03, 32'h40, 16'd3, "t5_ready", w);
        wait_done(d0 + 1, "t5_done");
        busy_stuck = 0;
        cnt_stat = 0;
        for (int i = base; i < base + 8; i++)
            if (log_addr[i] == 6'h28 && !log_wr[i] && log_data[i] == 32'h14) cnt_stat++;
        check("t5_log_n", log_n - base, 9);
        check("t5_stat_reads", cnt_stat, 8);
        check("t5_abort_write", {log_wr[base+8], log_addr[base+8], log_data[base+8]},
              {1'b1, 6'h00, 32'h0});
        check("t5_done_err", {done_id[d0], done_err[d0]}, 2'b01);
        check("t5_no_rsp", rsp_n - r0, 0);

        // Reset during an RXR access phase.
        load_rx(32'hDEAD_BEEF);
        stall_rxr = 1;
        issue(0, 14'h0004, 32'h03, 32'h80, 16'd1, "t6_ready", w);
        w = 0;
        for (int k = 0; k < 200 && w == 0; k++) begin
            @(negedge clk);
            if (psel_o && penable_o && paddr_o == 6'h24) w = 1;
        end
        check("t6_rxr_access", w, 1);
        r0 = rx_rd;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("t6_psel_after_rst", {psel_o, penable_o}, 0);
        check("t6_outputs_after_rst", {rsp_valid_o, done_o}, 0);
        rst_i = 1'b0;
        stall_rxr = 0;
        check("t6_no_pop", rx_rd - r0, 0);
        r0 = rsp_n; d0 = done_n;
        issue(0, 14'h0004, 32'h03, 32'h80, 16'd1, "t6_regrant", w);
        check("t6_idle_immediate", w, 0);
        wait_done(d0 + 1, "t6_done");
        check("t6_rsp", {rsp_data[r0], done_err[d0]}, {32'hDEAD_BEEF, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
